count_run_ctrl: RTL and testbench

Run controller that sequences an 8-bit enable-gated up-counter (inputs clk/enable, output q[7:0]; increments by 1 on each rising clk edge where enable=1; no reset). It issues a programmed number of prescaled enable strobes and tracks progress relative to the counter's starting value, so the counter needs no clear. It supports pause and abort, and checks after each run that the counter advanced by exactly the number of strobes issued. It sits between the top-level control logic and the counter instance.

---
 rtl/count_run_ctrl.sv | 129 ++++++++++++
 tb/tb_count_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/count_run_ctrl.sv
// Run controller for an enable-gated up-counter: issues a programmed number of
// prescaled enable strobes, supports pause/abort and checks the counter's advance.
module count_run_ctrl #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [WIDTH-1:0] issued
);
    typedef enum logic [2:0] {IDLE, RUN, HOLD, SETTLE, DONE} state_t;

    localparam logic [WIDTH-1:0] DIV_LAST = WIDTH'(DIV - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt, tgt_n, base, base_n, div_cnt, div_n, issued_n, adv;
    logic             settle_ph, settle_ph_n;
    logic             cnt_en_n, aborted_n, err_n, busy_n, done_n, step;

    assign adv    = cnt_q - base;
    assign busy_n = (state_n == RUN) || (state_n == HOLD) || (state_n == SETTLE);
    assign done_n = (state_n == DONE);

    always_comb begin
        state_n     = state;
        tgt_n       = tgt;
        base_n      = base;
        div_n       = div_cnt;
        issued_n    = issued;
        aborted_n   = aborted;
        err_n       = err;
        settle_ph_n = 1'b0;
        cnt_en_n    = 1'b0;
        step        = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (stop) begin
                    if (state == DONE) state_n = IDLE;
                end else if (start) begin
                    tgt_n     = target;
                    base_n    = cnt_q;
                    issued_n  = '0;
                    div_n     = '0;
                    aborted_n = 1'b0;
                    err_n     = 1'b0;
                    state_n   = (target != '0) ? RUN : SETTLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n   = SETTLE;
                    aborted_n = 1'b1;
                end else if (pause) begin
                    state_n = HOLD;
                end else begin
                    step = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_n   = SETTLE;
                    aborted_n = 1'b1;
                end else if (!pause) begin
                    // resuming edge counts as a run edge so a pause costs exactly its length
                    state_n = RUN;
                    step    = 1'b1;
                end
            end
            SETTLE: begin
                // first phase lets the final strobe's increment land in cnt_q
                settle_ph_n = 1'b1;
                if (settle_ph) begin
                    settle_ph_n = 1'b0;
                    err_n       = (adv != issued);
                    state_n     = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (step) begin
            if (div_cnt == DIV_LAST) begin
                cnt_en_n = 1'b1;
                div_n    = '0;
                issued_n = issued + 1'b1;
                if (issued_n == tgt) state_n = SETTLE;
            end else begin
                div_n = div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tgt       <= '0;
            base      <= '0;
            div_cnt   <= '0;
            issued    <= '0;
            settle_ph <= 1'b0;
            cnt_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            tgt       <= tgt_n;
            base      <= base_n;
            div_cnt   <= div_n;
            issued    <= issued_n;
            settle_ph <= settle_ph_n;
            cnt_en    <= cnt_en_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl: counter models, scoreboard of expected run results.
module tb_count_run_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, stop, pause, start1, ld, fault;
    logic [7:0] target, ld_val, q, q1, issued, issued1;
    logic       cnt_en, busy, done, aborted, err;
    logic       cnt_en1, busy1, done1, aborted1, err1;
    logic       done_q = 1'b0, done1_q = 1'b0;
    int         cyc = 0, tdone = 0, tdone1 = 0, np = 0, np1 = 0, en_seen = 0;
    int         pcyc[16];
    int         pcyc1[16];
    int         nvec = 0, nerr = 0;

    typedef struct {
        logic [7:0] issued;
        logic       err;
        logic       aborted;
        logic [7:0] q;
        int         tdone;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    count_run_ctrl #(.DIV(4), .WIDTH(8)) u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .target(target), .cnt_q(q), .cnt_en(cnt_en), .busy(busy), .done(done),
        .aborted(aborted), .err(err), .issued(issued));

    count_run_ctrl #(.DIV(1), .WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop), .pause(pause),
        .target(target), .cnt_q(q1), .cnt_en(cnt_en1), .busy(busy1), .done(done1),
        .aborted(aborted1), .err(err1), .issued(issued1));

    // counter models plus strobe/done timestamps; fault mode drops the 2nd enable
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        done_q  <= done;
        done1_q <= done1;
        if (done && !done_q) tdone <= cyc;
        if (done1 && !done1_q) tdone1 <= cyc;
        if (ld) begin
            q <= ld_val; q1 <= ld_val + 8'h33;
            np <= 0; np1 <= 0; en_seen <= 0;
        end else begin
            if (cnt_en) begin
                en_seen <= en_seen + 1;
                if (!(fault && en_seen == 1)) q <= q + 8'd1;
                if (np < 16) pcyc[np] <= cyc;
                np <= np + 1;
            end
            if (cnt_en1) begin
                q1 <= q1 + 8'd1;
                if (np1 < 16) pcyc1[np1] <= cyc;
                np1 <= np1 + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk); ld = 1'b1; ld_val = v;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic go(input logic [7:0] t, output int t0);
        target = t; start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_np(input string tag, input int n);
        int k = 0;
        while (np < n && k < 400) begin @(negedge clk); k++; end
        chk({tag, "_np_timeout"}, 32'(k < 400), 32'd1);
    endtask

    task automatic check_run(input string tag);
        exp_t e;
        int   k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk({tag, "_done_timeout"}, 32'(k < 400), 32'd1);
        @(negedge clk);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_issued"},  32'(issued),  32'(e.issued));
            chk({tag, "_err"},     32'(err),     32'(e.err));
            chk({tag, "_aborted"}, 32'(aborted), 32'(e.aborted));
            chk({tag, "_q"},       32'(q),       32'(e.q));
            chk({tag, "_tdone"},   32'(tdone),   32'(e.tdone));
            chk({tag, "_busy"},    32'(busy),    32'd0);
        end
    endtask

    // pulse k is seen at the edge DIV*(k+1)+1 after start; pulses from sh_from on are late by sh
    task automatic check_pulses(input string tag, input int t0, input int n,
                                input int sh_from, input int sh);
        chk({tag, "_npulses"}, 32'(np), 32'(n));
        for (int k = 0; k < n && k < 16; k++)
            chk($sformatf("%s_pulse%0d", tag, k), 32'(pcyc[k] - t0),
                32'(4 * (k + 1) + 1 + ((k >= sh_from) ? sh : 0)));
    endtask

    initial begin
        int t0, ts, k;
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; start1 = 1'b0;
        target = 8'd0; ld = 1'b0; ld_val = 8'd0; fault = 1'b0;
        #2;
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        @(negedge clk); reset = 1'b0;

        // basic run from 0x10
        load(8'h10); go(8'd5, t0);
        sb.push_back('{8'd5, 1'b0, 1'b0, 8'h15, t0 + 23});
        check_run("s1"); check_pulses("s1", t0, 5, 16, 0);

        // wrap through 0xFF, with a start during RUN that must be ignored
        load(8'hFE); go(8'd4, t0);
        sb.push_back('{8'd4, 1'b0, 1'b0, 8'h02, t0 + 19});
        wait_np("s2", 1);
        target = 8'd1; start = 1'b1; @(negedge clk); start = 1'b0;
        check_run("s2"); check_pulses("s2", t0, 4, 16, 0);

        // pause for 10 cycles after the 2nd strobe
        load(8'h10); go(8'd5, t0);
        sb.push_back('{8'd5, 1'b0, 1'b0, 8'h15, t0 + 33});
        wait_np("s3", 2);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        pause = 1'b0;
        chk("s3_no_strobe_paused", 32'(np), 32'd2);
        check_run("s3"); check_pulses("s3", t0, 5, 2, 10);

        // abort after the 3rd strobe, then stop in DONE and in IDLE
        load(8'h10); go(8'd9, t0);
        wait_np("s4", 3);
        stop = 1'b1; ts = cyc;
        sb.push_back('{8'd3, 1'b0, 1'b1, 8'h13, ts + 3});
        @(negedge clk); stop = 1'b0;
        check_run("s4");
        chk("s4_no_more_strobes", 32'(np), 32'd3);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        chk("s4_stop_done_done", 32'(done), 32'd0);
        chk("s4_stop_done_busy", 32'(busy), 32'd0);
        stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
        chk("s4_stop_idle_busy", 32'(busy), 32'd0);
        chk("s4_stop_idle_done", 32'(done), 32'd0);

        // zero target
        load(8'h20); go(8'd0, t0);
        sb.push_back('{8'd0, 1'b0, 1'b0, 8'h20, t0 + 3});
        check_run("s5");
        chk("s5_no_strobes", 32'(np), 32'd0);

        // DIV=1: three back-to-back enable cycles
        t0 = cyc; target = 8'd3; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        while (done1 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("d1_done_timeout", 32'(k < 400), 32'd1);
        @(negedge clk);
        chk("d1_issued", 32'(issued1), 32'd3);
        chk("d1_err", 32'(err1), 32'd0);
        chk("d1_npulses", 32'(np1), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("d1_pulse%0d", i), 32'(pcyc1[i] - t0), 32'(i + 2));
        chk("d1_tdone", 32'(tdone1 - t0), 32'd6);

        // counter that drops the 2nd enable must be flagged
        fault = 1'b1;
        load(8'h30); go(8'd4, t0);
        sb.push_back('{8'd4, 1'b1, 1'b0, 8'h33, t0 + 19});
        check_run("s6");
        fault = 1'b0;

        // asynchronous reset while a strobe is high
        load(8'h40); go(8'd5, t0);
        k = 0;
        while (cnt_en !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("s6r_en_timeout", 32'(k < 400), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("s6r_cnt_en", 32'(cnt_en), 32'd0);
        chk("s6r_busy", 32'(busy), 32'd0);
        chk("s6r_issued", 32'(issued), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("s6r_idle_busy", 32'(busy), 32'd0);
        chk("s6r_idle_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
